// File: rtl/case_3_prod_accum_if.sv
// Handshake bundle between the product multiplier, the run accumulator and its consumer.
// The slave modport is the accumulator's view; the master modport is the surrounding datapath.
interface case_3_prod_accum_if #(
  parameter int PROD_WIDTH = 10,
  parameter int ACC_WIDTH  = 16,
  parameter int CNT_WIDTH  = 8
);
  logic [CNT_WIDTH-1:0]  cfg_len;
  logic [PROD_WIDTH-1:0] prod_data;
  logic                  prod_valid;
  logic                  prod_ready;
  logic [ACC_WIDTH-1:0]  acc_data;
  logic                  acc_ovf;
  logic                  acc_valid;
  logic                  acc_ready;

  modport master (
    output cfg_len, prod_data, prod_valid, acc_ready,
    input  prod_ready, acc_data, acc_ovf, acc_valid
  );

  modport slave (
    input  cfg_len, prod_data, prod_valid, acc_ready,
    output prod_ready, acc_data, acc_ovf, acc_valid
  );
endinterface

// File: rtl/case_3_prod_accum.sv
// Saturating run accumulator: sums cfg_len signed products, then holds the sum and a
// sticky overflow flag on a registered valid/ready output until it is taken.
module case_3_prod_accum #(
  parameter int PROD_WIDTH = 10,
  parameter int ACC_WIDTH  = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  case_3_prod_accum_if.slave bus
);

  typedef enum logic {ACCUM, OUT} state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_sat;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_WIDTH-1:0] len_q, len_d, cfg_eff, len_eff;
  logic                 ovf_q, ovf_d;
  logic                 beat, sat_hit;

  assign bus.prod_ready = ap_rst_n && (state_q == ACCUM);
  assign bus.acc_valid  = (state_q == OUT);
  assign bus.acc_data   = acc_q;
  assign bus.acc_ovf    = ovf_q;

  assign beat    = bus.prod_valid && bus.prod_ready;
  assign cnt_inc = cnt_q + CNT_ONE;
  assign cfg_eff = (bus.cfg_len == '0) ? CNT_ONE : bus.cfg_len;
  // The first beat of a run compares against the length it is latching right now.
  assign len_eff = (cnt_q == '0) ? cfg_eff : len_q;

  // One guard bit is enough: disagreement between the top two bits means the sum left range.
  assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q}
                  + {{(ACC_WIDTH+1-PROD_WIDTH){bus.prod_data[PROD_WIDTH-1]}}, bus.prod_data};
  assign sat_hit  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
  assign acc_sat  = !sat_hit ? sum_wide[ACC_WIDTH-1:0]
                  : (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (beat) begin
          acc_d = acc_sat;
          ovf_d = ovf_q | sat_hit;
          cnt_d = cnt_inc;
          if (cnt_q == '0) len_d = cfg_eff;
          if (cnt_inc == len_eff) state_d = OUT;
        end
      end
      OUT: begin
        if (bus.acc_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= CNT_ONE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
